// File: rtl/e_mdu_ctrl_if.sv
// Pipeline-side bundle for the E-stage multiply/divide sequencer:
// operation request, forwarded operands, and HI/LO/stall results.
interface e_mdu_ctrl_if;
    logic        in_start;
    logic [3:0]  in_op;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic        in_d_is_md;
    logic        out_busy;
    logic        out_stall;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic [31:0] out_rdata;

    modport master (
        output in_start, in_op, in_rs, in_rt, in_d_is_md,
        input  out_busy, out_stall, out_hi, out_lo, out_rdata
    );

    modport slave (
        input  in_start, in_op, in_rs, in_rt, in_d_is_md,
        output out_busy, out_stall, out_hi, out_lo, out_rdata
    );
endinterface

// File: rtl/e_mdu_ctrl.sv
// E-stage MDU sequencer: owns HI/LO, models MULT/DIV latency with a countdown
// FSM, serves MFHI/MFLO and requests a D-stage stall on MDU collisions.
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         in_clk,
    input  logic         in_reset_n,
    e_mdu_ctrl_if.slave  mdu
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam logic [3:0] MULT_LAT_M1 = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAT_M1  = 4'(DIV_CYCLES - 1);

    state_e      state;
    logic [3:0]  counter;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pending_hi;
    logic [31:0] pending_lo;

    logic        is_long_op;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] sdiv_q;
    logic [31:0] sdiv_r;
    logic [31:0] udiv_q;
    logic [31:0] udiv_r;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [3:0]  lat_m1;

    assign is_long_op = mdu.in_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};

    // Sign-extending to 64 bits makes the low half of the unsigned product the signed product.
    assign prod_s = {{32{mdu.in_rs[31]}}, mdu.in_rs} * {{32{mdu.in_rt[31]}}, mdu.in_rt};
    assign prod_u = {32'd0, mdu.in_rs} * {32'd0, mdu.in_rt};

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sdiv_q = '0;
        sdiv_r = '0;
        if (mdu.in_rt == 32'd0) begin
            sdiv_q = 32'hFFFF_FFFF;
            sdiv_r = mdu.in_rs;
        end else if (mdu.in_rs == 32'h8000_0000 && mdu.in_rt == 32'hFFFF_FFFF) begin
            sdiv_q = 32'h8000_0000;
            sdiv_r = 32'd0;
        end else begin
            sdiv_q = $signed(mdu.in_rs) / $signed(mdu.in_rt);
            sdiv_r = $signed(mdu.in_rs) % $signed(mdu.in_rt);
        end
    end

    always_comb begin
        udiv_q = '0;
        udiv_r = '0;
        if (mdu.in_rt == 32'd0) begin
            udiv_q = 32'hFFFF_FFFF;
            udiv_r = mdu.in_rs;
        end else begin
            udiv_q = mdu.in_rs / mdu.in_rt;
            udiv_r = mdu.in_rs % mdu.in_rt;
        end
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        lat_m1 = '0;
        case (mdu.in_op)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                lat_m1 = MULT_LAT_M1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                lat_m1 = MULT_LAT_M1;
            end
            OP_DIV: begin
                res_hi = sdiv_r;
                res_lo = sdiv_q;
                lat_m1 = DIV_LAT_M1;
            end
            OP_DIVU: begin
                res_hi = udiv_r;
                res_lo = udiv_q;
                lat_m1 = DIV_LAT_M1;
            end
            default: ;
        endcase
    end

    // The result is computed at issue and parked; the countdown only models latency.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state      <= S_IDLE;
            counter    <= '0;
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mdu.in_start) begin
                        if (is_long_op) begin
                            pending_hi <= res_hi;
                            pending_lo <= res_lo;
                            counter    <= lat_m1;
                            state      <= S_BUSY;
                        end else if (mdu.in_op == OP_MTHI) begin
                            hi <= mdu.in_rs;
                        end else if (mdu.in_op == OP_MTLO) begin
                            lo <= mdu.in_rs;
                        end
                    end
                end
                S_BUSY: begin
                    // Any in_start seen here is dropped; the stall keeps a correct pipeline from issuing it.
                    if (counter == 4'd0) begin
                        hi    <= pending_hi;
                        lo    <= pending_lo;
                        state <= S_IDLE;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mdu.out_busy  = (state == S_BUSY);
    assign mdu.out_hi    = hi;
    assign mdu.out_lo    = lo;
    assign mdu.out_stall = mdu.in_d_is_md & ((state == S_BUSY) | (mdu.in_start & is_long_op));

    always_comb begin
        mdu.out_rdata = '0;
        if (mdu.in_op == OP_MFHI) begin
            mdu.out_rdata = hi;
        end else if (mdu.in_op == OP_MFLO) begin
            mdu.out_rdata = lo;
        end
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl: expected HI/LO pairs are queued at issue and
// compared when out_busy falls; also covers MTHI/MTLO, stall, and async reset.
module tb_e_mdu_ctrl;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    e_mdu_ctrl_if mdu ();

    e_mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .in_clk    (clk),
        .in_reset_n(rst_n),
        .mdu       (mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mdu.in_start = 1'b0;
        mdu.in_op    = 4'd0;
    endtask

    // Issues one long op, counts busy cycles, then compares against the queued result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int lat, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic md, input int inject_at);
        exp_t e;
        int   n;
        sb.push_back('{hi: ehi, lo: elo});
        @(negedge clk);
        mdu.in_start   = 1'b1;
        mdu.in_op      = op;
        mdu.in_rs      = rs;
        mdu.in_rt      = rt;
        mdu.in_d_is_md = md;
        #1;
        check({tag, "/stall_at_start"}, 32'(mdu.out_stall), 32'(md));
        @(posedge clk);
        #1;
        idle_inputs();
        n = 0;
        forever begin
            @(negedge clk);
            idle_inputs();
            if (!mdu.out_busy || n >= 40) break;
            n++;
            if (md) check({tag, "/stall_busy"}, 32'(mdu.out_stall), 32'd1);
            if (n == inject_at) begin
                $display("note: %s issuing in_start while busy (protocol violation)", tag);
                mdu.in_start = 1'b1;
                mdu.in_op    = 4'd4;
                mdu.in_rs    = 32'd1;
                mdu.in_rt    = 32'd1;
            end
        end
        check({tag, "/busy_cycles"}, 32'(n), 32'(lat));
        e = sb.pop_front();
        check({tag, "/hi"}, mdu.out_hi, e.hi);
        check({tag, "/lo"}, mdu.out_lo, e.lo);
        check({tag, "/stall_after"}, 32'(mdu.out_stall), 32'd0);
        mdu.in_d_is_md = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();
        mdu.in_rs      = 32'd0;
        mdu.in_rt      = 32'd0;
        mdu.in_d_is_md = 1'b1;
        #12;
        check("reset/busy", 32'(mdu.out_busy), 32'd0);
        check("reset/stall", 32'(mdu.out_stall), 32'd0);
        check("reset/hi", mdu.out_hi, 32'd0);
        check("reset/lo", mdu.out_lo, 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        mdu.in_d_is_md = 1'b0;

        run_op("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
        run_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0, 0);
        run_op("div_neg_dividend", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("div_neg_divisor", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("div_by_zero", 4'd3, 32'h1234_5678, 32'd0, 10, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("divu_by_zero", 4'd4, 32'h0000_00AB, 32'd0, 10, 32'h0000_00AB, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("div_overflow", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0, 0);

        // MTHI then MFHI; LO keeps the overflow quotient.
        @(negedge clk);
        mdu.in_start = 1'b1;
        mdu.in_op    = 4'd7;
        mdu.in_rs    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mdu.in_start = 1'b0;
        mdu.in_op    = 4'd5;
        #1;
        check("mthi/busy", 32'(mdu.out_busy), 32'd0);
        check("mthi/hi", mdu.out_hi, 32'hDEAD_BEEF);
        check("mthi/rdata", mdu.out_rdata, 32'hDEAD_BEEF);
        check("mthi/lo_kept", mdu.out_lo, 32'h8000_0000);

        @(negedge clk);
        mdu.in_start = 1'b1;
        mdu.in_op    = 4'd8;
        mdu.in_rs    = 32'h0123_4567;
        @(posedge clk);
        #1;
        mdu.in_start = 1'b0;
        mdu.in_op    = 4'd6;
        #1;
        check("mtlo/lo", mdu.out_lo, 32'h0123_4567);
        check("mtlo/rdata", mdu.out_rdata, 32'h0123_4567);
        check("mtlo/hi_kept", mdu.out_hi, 32'hDEAD_BEEF);
        mdu.in_op = 4'd0;
        #1;
        check("rdata_none", mdu.out_rdata, 32'd0);

        run_op("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'd1, 1'b0, 0);
        run_op("mult_stall_inject", 4'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b1, 2);

        // Reserved op code behaves as NONE.
        @(negedge clk);
        mdu.in_start = 1'b1;
        mdu.in_op    = 4'd9;
        mdu.in_rs    = 32'h5555_5555;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        check("op9/busy", 32'(mdu.out_busy), 32'd0);
        check("op9/hi", mdu.out_hi, 32'd0);
        check("op9/lo", mdu.out_lo, 32'd42);

        // Abort a DIV with reset in its fourth busy cycle.
        @(negedge clk);
        mdu.in_start   = 1'b1;
        mdu.in_op      = 4'd3;
        mdu.in_rs      = 32'd100;
        mdu.in_rt      = 32'd3;
        mdu.in_d_is_md = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("abort/busy_before", 32'(mdu.out_busy), 32'd1);
        #1;
        rst_n = 1'b0;
        mdu.in_op = 4'd6;
        #1;
        check("abort/busy", 32'(mdu.out_busy), 32'd0);
        check("abort/stall", 32'(mdu.out_stall), 32'd0);
        check("abort/hi", mdu.out_hi, 32'd0);
        check("abort/lo", mdu.out_lo, 32'd0);
        check("abort/rdata", mdu.out_rdata, 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        mdu.in_d_is_md = 1'b0;
        idle_inputs();
        for (int i = 0; i < 12; i++) @(negedge clk);
        check("abort/idle_busy", 32'(mdu.out_busy), 32'd0);
        check("abort/no_commit_hi", mdu.out_hi, 32'd0);
        check("abort/no_commit_lo", mdu.out_lo, 32'd0);

        run_op("multu_after_reset", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE, 1'b0, 0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
